// File: rtl/control_unit.sv
// control_unit: multi-cycle sequencer for a small 16-bit-instruction CPU.
// Each instruction walks FETCH -> DECODE -> EXEC -> WB; opcode F parks the
// unit in HALT until reset. Every output is a flop, so nothing from the
// inputs reaches an output within the same cycle.
module control_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic [15:0] instr,
    input  logic        flag_z,
    input  logic        flag_c,
    output logic [7:0]  pc,
    output logic [2:0]  in_rx_selector,
    output logic [2:0]  in_ry_selector,
    output logic [2:0]  alu_op,
    output logic        alu_en,
    output logic        reg_write_en,
    output logic [1:0]  reg_in_sel,
    output logic [7:0]  imm,
    output logic        port_out_en,
    output logic        halted
);

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        WB,
        HALT
    } state_t;

    localparam logic [3:0] OP_LDI  = 4'h8;
    localparam logic [3:0] OP_IN   = 4'h9;
    localparam logic [3:0] OP_OUT  = 4'hA;
    localparam logic [3:0] OP_JMP  = 4'hB;
    localparam logic [3:0] OP_JZ   = 4'hC;
    localparam logic [3:0] OP_JC   = 4'hD;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [1:0] SEL_ALU  = 2'd0;
    localparam logic [1:0] SEL_IMM  = 2'd1;
    localparam logic [1:0] SEL_PORT = 2'd2;

    state_t      state, state_n;
    logic [15:0] ir, ir_n;
    logic        jumped, jumped_n;
    logic [7:0]  pc_n;
    logic [2:0]  rx_n, ry_n, alu_op_n;
    logic [7:0]  imm_n;
    logic [1:0]  reg_in_sel_n;
    logic        alu_en_n, reg_write_en_n, port_out_en_n, halted_n;

    logic [3:0]  opcode;
    logic        is_alu;
    logic        take_jump;

    assign opcode    = ir[15:12];
    assign is_alu    = (opcode != 4'h0) && !opcode[3];
    assign take_jump = (opcode == OP_JMP) ||
                       ((opcode == OP_JZ) && flag_z) ||
                       ((opcode == OP_JC) && flag_c);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= FETCH;
        else       state <= state_n;
    end

    // Next state and next values of every registered output; strobes default low.
    always_comb begin
        state_n        = state;
        ir_n           = ir;
        jumped_n       = jumped;
        pc_n           = pc;
        rx_n           = in_rx_selector;
        ry_n           = in_ry_selector;
        imm_n          = imm;
        alu_op_n       = alu_op;
        reg_in_sel_n   = reg_in_sel;
        alu_en_n       = 1'b0;
        reg_write_en_n = 1'b0;
        port_out_en_n  = 1'b0;
        halted_n       = halted;

        case (state)
            FETCH: begin
                if (run) begin
                    ir_n     = instr;
                    jumped_n = 1'b0;
                    state_n  = DECODE;
                end
            end
            DECODE: begin
                rx_n  = ir[11:9];
                ry_n  = ir[8:6];
                imm_n = ir[7:0];
                if (opcode == OP_HALT) begin
                    halted_n = 1'b1;
                    state_n  = HALT;
                end else begin
                    // ALU and port strobes are launched here so they are
                    // visible exactly during the EXEC cycle.
                    alu_en_n      = is_alu;
                    if (is_alu) alu_op_n = opcode[2:0];
                    port_out_en_n = (opcode == OP_OUT);
                    state_n       = EXEC;
                end
            end
            EXEC: begin
                if (take_jump) begin
                    pc_n     = imm;
                    jumped_n = 1'b1;
                end
                if (is_alu) begin
                    reg_write_en_n = 1'b1;
                    reg_in_sel_n   = SEL_ALU;
                end else if (opcode == OP_LDI) begin
                    reg_write_en_n = 1'b1;
                    reg_in_sel_n   = SEL_IMM;
                end else if (opcode == OP_IN) begin
                    reg_write_en_n = 1'b1;
                    reg_in_sel_n   = SEL_PORT;
                end
                state_n = WB;
            end
            WB: begin
                if (!jumped) pc_n = pc + 8'd1;
                state_n = FETCH;
            end
            HALT: begin
                halted_n = 1'b1;
            end
            default: begin
                state_n = FETCH;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            ir             <= '0;
            jumped         <= 1'b0;
            pc             <= '0;
            in_rx_selector <= '0;
            in_ry_selector <= '0;
            imm            <= '0;
            alu_op         <= '0;
            reg_in_sel     <= '0;
            alu_en         <= 1'b0;
            reg_write_en   <= 1'b0;
            port_out_en    <= 1'b0;
            halted         <= 1'b0;
        end else begin
            ir             <= ir_n;
            jumped         <= jumped_n;
            pc             <= pc_n;
            in_rx_selector <= rx_n;
            in_ry_selector <= ry_n;
            imm            <= imm_n;
            alu_op         <= alu_op_n;
            reg_in_sel     <= reg_in_sel_n;
            alu_en         <= alu_en_n;
            reg_write_en   <= reg_write_en_n;
            port_out_en    <= port_out_en_n;
            halted         <= halted_n;
        end
    end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 run  input  1  execution enable; sampled only in FETCH.
REQ-004 instr  input  16  program memory word at address pc, valid combinationally in the same cycle.
REQ-005 flag_z  input  1  datapath zero flag, registered by datapath.
REQ-006 flag_c  input  1  datapath carry flag, registered by datapath.
REQ-007 pc  output  8  program counter / program memory address.
REQ-008 in_rx_selector  output  3  register file port X select; destination for writes.
REQ-009 in_ry_selector  output  3  register file port Y select.
REQ-010 alu_op  output  3  ALU operation code; meaningful only while alu_en=1.
REQ-011 alu_en  output  1  one-cycle ALU compute/flag-update strobe.
REQ-012 reg_write_en  output  1  one-cycle register file write strobe.
REQ-013 reg_in_sel  output  2  write-data mux: 0=ALU result, 1=imm, 2=port_input, 3=unused.
REQ-014 imm  output  8  immediate field of the current instruction.
REQ-015 port_out_en  output  1  one-cycle strobe that latches register rx into port_output.
REQ-016 halted  output  1  high while in HALT state.

Function
REQ-017 The FSM SHALL have states FETCH, DECODE, EXEC, WB, HALT; every non-halting instruction takes exactly 4 cycles, FETCH through WB.
REQ-018 FETCH: if run=1, IR<=instr and next=DECODE; if run=0, remain in FETCH with IR and pc unchanged.
REQ-019 Decoding: opcode=IR[15:12], rx=IR[11:9], ry=IR[8:6], imm=IR[7:0].
REQ-020 Opcodes: 0 NOP; 1 ADD; 2 SUB; 3 AND; 4 OR; 5 XOR; 6 SHL; 7 SHR; 8 LDI; 9 IN; A OUT; B JMP; C JZ; D JC; E NOP; F HALT.
REQ-021 DECODE: in_rx_selector, in_ry_selector and imm SHALL be registered from IR and held constant through EXEC and WB.
REQ-022 EXEC: for opcodes 1-7, alu_en=1 for exactly one cycle with alu_op=opcode[2:0]; alu_en=0 in all other cycles.
REQ-023 EXEC: JMP is always taken; JZ is taken iff flag_z=1; JC is taken iff flag_c=1, with flags sampled in the EXEC cycle. If taken, pc<=imm at the end of EXEC.
REQ-024 EXEC: OUT asserts port_out_en for exactly one cycle.
REQ-025 WB: opcodes 1-7 assert reg_write_en with reg_in_sel=0; LDI asserts it with reg_in_sel=1; IN asserts it with reg_in_sel=2. reg_write_en is one cycle only and is never asserted for any other opcode.
REQ-026 WB: pc<=pc+1 (modulo 256, so 0xFF wraps to 0x00) unless a jump was taken in this instruction; next state=FETCH.
REQ-027 HALT (opcode F): after DECODE, go to HALT; pc is not incremented; no strobes are asserted; halted=1; remain until reset regardless of run.
REQ-028 reg_in_sel SHALL hold its last value when reg_write_en=0.
REQ-029 All outputs SHALL be registered with no combinational path from inputs to outputs.

Reset
REQ-030 With reset=1 at a rising edge, the next state SHALL be: state=FETCH, pc=0, IR=0, selectors=0, imm=0, alu_op=0, reg_in_sel=0, all strobes=0, halted=0.
REQ-031 Reset SHALL override every state, including mid-instruction and HALT, and no strobe from the aborted instruction is emitted after reset.
REQ-032 Reset has priority over run; the first fetch after reset reads address 0.

Verification
REQ-033 LDI r3,0x5A at pc=0, run=1: reg_write_en pulses in cycle 4 with in_rx_selector=3, reg_in_sel=1, imm=0x5A; then pc=1.
REQ-034 ADD r1,r2 (0x1280): alu_en pulses in cycle 3 with alu_op=1, rx=1, ry=2; reg_write_en pulses in cycle 4 with reg_in_sel=0; then pc increments by 1.
REQ-035 JZ 0x40 with flag_z=1 -> pc=0x40 and no reg_write_en; with flag_z=0 -> pc=old pc+1.
REQ-036 NOP at pc=0xFF -> pc wraps to 0x00. Holding run=0 for 10 cycles -> pc, state and strobes are unchanged.
REQ-037 HALT at pc=5 -> halted=1 and pc stays 5 for 20 cycles. Then reset=1 for one cycle -> halted=0, pc=0.
REQ-038 Asserting reset during EXEC of ADD -> no reg_write_en pulse; all outputs return to their reset values.
